// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-adder FSM state encoding and operand width limits.
package alu_pkg;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell; the bit-slice reused by the serial adder.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one fulladder slice and a registered carry.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             Cout,
  output logic             Ovf
`else
  output logic             Cout
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  fulladder u_fa (
    .A   (opa[0]),
    .B   (opb[0]),
    .Cin (carry),
    .Sum (fa_s),
    .Cout(fa_co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_res1
    assign res_nxt = fa_s;
  end else begin : g_resn
    assign res_nxt = {fa_s, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            opa   <= A;
            opb   <= Sub ? ~B : B;
            carry <= Sub ? 1'b1 : Cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= res_nxt;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          // Results are published on the same edge that raises Done.
          if (cnt == LAST) begin
            state <= DONE;
            Sum   <= res_nxt;
            Cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= carry ^ fa_co;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: cycle model + per-op literal expectations, plus a WIDTH=1 instance.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, Start, Sub, Cin;
  logic [W-1:0] A, B, Sum;
  logic         Busy, Done, Cout;
  logic         start1, sub1, a1, b1, cin1, busy1, done1, sum1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Ovf, ovf1;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .Start(Start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum),
`ifdef SERIAL_ADDER_OVF_EN
    .Cout(Cout), .Ovf(Ovf)
`else
    .Cout(Cout)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .Start(start1), .Sub(sub1), .A(a1), .B(b1), .Cin(cin1),
    .Busy(busy1), .Done(done1), .Sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
    .Cout(cout1), .Ovf(ovf1)
`else
    .Cout(cout1)
`endif
  );

  int checks = 0, errors = 0, done_cnt = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain (WIDTH+1)-bit addition; subtraction as A + ~B + 1.
  function automatic logic [W+1:0] ref_op(input logic sub, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Model: an accepted request completes WIDTH edges later; requests while busy are dropped.
  int           left = 0;
  logic         m_done = 0, m_cout = 0, m_ovf = 0, p_cout, p_ovf;
  logic [W-1:0] m_sum = '0, p_sum;
  always @(posedge clk) begin
    logic [W+1:0] r;
    if (rst) begin
      left = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (Start) begin
        r = ref_op(Sub, A, B, Cin);
        p_sum = r[W-1:0]; p_cout = r[W]; p_ovf = r[W+1];
        left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(Busy), 64'(left > 0));
      chk("done", 64'(Done), 64'(m_done));
      chk("sum",  64'(Sum),  64'(m_sum));
      chk("cout", 64'(Cout), 64'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf",  64'(Ovf),  64'(m_ovf));
`endif
      if (Done === 1'b1) done_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge where Done is seen, so back-to-back calls chain.
  task automatic run_op(input string nm, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] es,
                        input logic ec, input logic eo, input int interfere_at);
    int cyc = 0;
    bit got = 0;
    Sub = sub; A = a; B = b; Cin = cin; Start = 1;
    while (!got && cyc < 4 * W + 10) begin
      @(negedge clk);
      cyc++;
      if (interfere_at != 0 && cyc == interfere_at) begin
        Start = 1; Sub = 0; A = 8'hAA; B = 8'hAA; Cin = 1;
      end else begin
        Start = 0;
      end
      if (Done === 1'b1) got = 1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s_timeout: no Done within %0d cycles", nm, cyc);
    end else begin
      chk({nm, "_lat"},  64'(cyc), 64'(W + 1));
      chk({nm, "_sum"},  64'(Sum), 64'(es));
      chk({nm, "_cout"}, 64'(Cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      chk({nm, "_ovf"},  64'(Ovf), 64'(eo));
`else
      if (eo !== 1'bx) begin end
`endif
    end
  endtask

  initial begin
    int d0;
    rst = 1; Start = 0; Sub = 0; A = '0; B = '0; Cin = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", 64'(Busy), 0);
    chk("rst_done", 64'(Done), 0);
    chk("rst_sum",  64'(Sum), 0);
    chk("rst_cout", 64'(Cout), 0);
    chk("rst1_busy", 64'(busy1), 0);
    cmp_en = 1;
    @(negedge clk);

    run_op("add0f01", 0, 8'h0F, 8'h01, 0, 8'h10, 0, 0, 0);
    @(negedge clk);
    run_op("addff01", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
    @(negedge clk);
    run_op("addff00c", 0, 8'hFF, 8'h00, 1, 8'h00, 1, 0, 0);
    @(negedge clk);
    run_op("sub0507", 1, 8'h05, 8'h07, 1, 8'hFE, 0, 0, 0);
    run_op("sub0705b2b", 1, 8'h07, 8'h05, 0, 8'h02, 1, 0, 0);
    @(negedge clk);
    run_op("add7f01", 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 0);
    @(negedge clk);
    run_op("add8080", 0, 8'h80, 8'h80, 0, 8'h00, 1, 1, 0);
    @(negedge clk);
    run_op("add1020", 0, 8'h10, 8'h20, 0, 8'h30, 0, 0, 0);
    @(negedge clk);

    // Second Start while busy must be dropped: one Done, first operands' result.
    d0 = done_cnt;
    run_op("ignore", 0, 8'h33, 8'h44, 0, 8'h77, 0, 0, 3);
    repeat (W + 3) @(negedge clk);
    chk("ignore_ndone", 64'(done_cnt - d0), 1);

    // Reset mid-operation: outputs cleared next cycle, no Done afterwards.
    Sub = 0; A = 8'h12; B = 8'h34; Cin = 0; Start = 1;
    @(negedge clk);
    Start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", 64'(Busy), 0);
    chk("midrst_done", 64'(Done), 0);
    chk("midrst_sum",  64'(Sum), 0);
    chk("midrst_cout", 64'(Cout), 0);
    d0 = done_cnt;
    repeat (W + 3) @(negedge clk);
    chk("midrst_ndone", 64'(done_cnt - d0), 0);

    // WIDTH=1: 1+1 -> Sum 0, Cout 1, Done one cycle after Start.
    a1 = 1; b1 = 1; cin1 = 0; sub1 = 0; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("w1_busy", 64'(busy1), 1);
    chk("w1_done_early", 64'(done1), 0);
    @(negedge clk);
    chk("w1_done", 64'(done1), 1);
    chk("w1_sum",  64'(sum1), 0);
    chk("w1_cout", 64'(cout1), 1);
    @(negedge clk);
    chk("w1_done_pulse", 64'(done1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor for the ALU. Adds or subtracts two WIDTH-bit operands one bit per clock using a single instance of the team's `fulladder` cell and a registered carry, trading latency for area. It is the sequential successor to the combinational full adder and is the multi-cycle arithmetic path in the ALU, controlled by a Start/Busy/Done handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits, legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only while Busy is low.
- Sub  input  1  0 computes A+B+Cin; 1 computes A-B, where Cin is ignored.
- A  input  WIDTH  first operand, captured when Start is accepted.
- B  input  WIDTH  second operand, captured when Start is accepted.
- Cin  input  1  carry-in, captured when Start is accepted.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse when Sum and Cout become valid.
- Sum  output  WIDTH  result; held until the next accepted Start.
- Cout  output  1  final carry out; for Sub, 1 means no borrow.
- Ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE to RUN: on Start=1. In the same edge:
  - opA <= A; opB <= Sub ? ~B : B;
  - carry <= Sub ? 1 : Cin;
  - bit counter <= 0.
- RUN, each cycle:
  - The fulladder takes opA[0], opB[0] and carry.
  - The sum bit shifts into the MSB of the result shift register, which shifts right.
  - opA and opB shift right. carry <= fulladder Cout. The counter increments.
- RUN to DONE: after the bit with counter = WIDTH-1 is processed.
- DONE: Sum <= result register and Cout <= carry are already visible. Done=1 for exactly this cycle, then the FSM returns to IDLE.
- A Start asserted in the DONE cycle is accepted, and the FSM goes directly to RUN. This gives back-to-back operation.
- A Start asserted while Busy is high is ignored. Operands are not re-captured.
- Arithmetic is modulo 2^WIDTH. Cout is the carry out of bit WIDTH-1.
- With WIDTH=1 the operation completes after a single RUN cycle.

## Timing
- Reset values: Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, FSM=IDLE, internal registers=0.
- Reset mid-operation aborts the operation immediately at the next edge. No Done is produced.
- Latency: if Start is sampled at edge k, Busy is high after edges k..k+WIDTH-1, and Done is high after edge k+WIDTH, for one cycle.
- Throughput: one operation per WIDTH+1 cycles.
- Sum and Cout change only on the edge that raises Done, or on reset. They are stable at all other times.
- If rst and Start are high together, rst wins.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Ovf is a port and is registered alongside Cout.
  - Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This requires one extra flop holding the carry from the previous bit.
- SERIAL_ADDER_OVF_EN undefined:
  - The Ovf port and its flop do not exist.
  - All other behaviour is identical.

## Structure
- Shared package `alu_pkg`: the FSM state typedef (IDLE, RUN, DONE) and the WIDTH legality limits.
- Sub-module: exactly one instance of the existing `fulladder` (ports A, B, Cin, Sum, Cout) as the bit-slice.
- All other logic is local: FSM, counter sized $clog2(WIDTH+1), and shift registers.

## Test plan
All scenarios use WIDTH=8 unless stated.
- A=0x0F, B=0x01, Cin=0, Sub=0, Start at edge k -> Done at edge k+8; Sum=0x10, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Repeat with Cin=1 and B=0x00 -> Sum=0x00, Cout=1.
- Sub=1, A=0x05, B=0x07 -> Sum=0xFE, Cout=0. Then Sub=1, A=0x07, B=0x05, Start in the DONE cycle -> back-to-back operation, Sum=0x02, Cout=1.
- With OVF_EN:
  - A=0x7F, B=0x01 -> Ovf=1, Sum=0x80.
  - A=0x80, B=0x80 -> Ovf=1, Cout=1.
  - A=0x10, B=0x20 -> Ovf=0.
- Start pulsed again at cycle k+3 with different operands -> ignored; the result matches the first operands and there is exactly one Done.
- rst at cycle k+4 -> all outputs 0 next cycle, no Done. WIDTH=1 build: A=1, B=1 -> Done 1 cycle after Start, Sum=0, Cout=1.
